// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_pkg
// Description : Shared ALU operation encodings and forwarding helper for the
//               ID/EX pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_stage_pkg;

    localparam int c_alu_sel_width = 4;

    localparam logic [c_alu_sel_width-1:0] c_add_op = 4'd0;
    localparam logic [c_alu_sel_width-1:0] c_sub_op = 4'd1;
    localparam logic [c_alu_sel_width-1:0] c_and_op = 4'd2;
    localparam logic [c_alu_sel_width-1:0] c_or_op  = 4'd3;
    localparam logic [c_alu_sel_width-1:0] c_xor_op = 4'd4;
    localparam logic [c_alu_sel_width-1:0] c_nor_op = 4'd5;
    localparam logic [c_alu_sel_width-1:0] c_slt_op = 4'd6;
    localparam logic [c_alu_sel_width-1:0] c_sl_op  = 4'd7;
    localparam logic [c_alu_sel_width-1:0] c_srl_op = 4'd8;
    localparam logic [c_alu_sel_width-1:0] c_sra_op = 4'd9;
    localparam logic [c_alu_sel_width-1:0] c_lui_op = 4'd10;

    // r0 is hardwired to zero, so a pending write to it must never be bypassed.
    function automatic logic fwd_hit(input logic       reg_write,
                                     input logic [4:0] rd,
                                     input logic [4:0] addr);
        return reg_write && (rd == addr) && (rd != 5'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : fwd_mux
// Description : Operand bypass selector; EX/MEM result beats MEM/WB result,
//               which beats the value read from the register file.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
    import id_ex_stage_pkg::*;
(
    input  logic [4:0]  addr,
    input  logic [31:0] reg_data,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic [31:0] data
);

    always_comb begin
        data = reg_data;
        if (fwd_hit(exmem_reg_write, exmem_rd, addr)) begin
            data = exmem_result;
        end else if (fwd_hit(memwb_reg_write, memwb_rd, addr)) begin
            data = memwb_result;
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with operand forwarding, ALU operand
//               selection and load-use hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int ALU_SELECTION_WIDTH = c_alu_sel_width
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           flush,
    input  logic                           id_valid,
    input  logic [4:0]                     id_rs_addr,
    input  logic [4:0]                     id_rt_addr,
    input  logic [4:0]                     id_rd_addr,
    input  logic [31:0]                    id_rs_data,
    input  logic [31:0]                    id_rt_data,
    input  logic [31:0]                    id_imm,
    input  logic [4:0]                     id_shamt,
    input  logic [ALU_SELECTION_WIDTH-1:0] id_alu_s,
    input  logic                           id_src_imm,
    input  logic                           id_src_shamt,
    input  logic                           id_reg_write,
    input  logic                           id_mem_read,
    input  logic                           id_mem_write,
    input  logic                           exmem_reg_write,
    input  logic [4:0]                     exmem_rd,
    input  logic [31:0]                    exmem_result,
    input  logic                           memwb_reg_write,
    input  logic [4:0]                     memwb_rd,
    input  logic [31:0]                    memwb_result,
    output logic [31:0]                    alu_a,
    output logic [31:0]                    alu_b,
    output logic [ALU_SELECTION_WIDTH-1:0] alu_s,
    output logic                           ex_valid,
    output logic                           ex_reg_write,
    output logic                           ex_mem_read,
    output logic                           ex_mem_write,
    output logic [4:0]                     ex_rd,
    output logic [31:0]                    ex_store_data,
    output logic                           load_use_hazard
);

    localparam logic [ALU_SELECTION_WIDTH-1:0] c_bubble_op = ALU_SELECTION_WIDTH'(c_add_op);

    logic                           r_valid;
    logic                           r_reg_write;
    logic                           r_mem_read;
    logic                           r_mem_write;
    logic                           r_src_imm;
    logic                           r_src_shamt;
    logic [4:0]                     r_rd;
    logic [4:0]                     r_rs_addr;
    logic [4:0]                     r_rt_addr;
    logic [4:0]                     r_shamt;
    logic [31:0]                    r_rs_data;
    logic [31:0]                    r_rt_data;
    logic [31:0]                    r_imm;
    logic [ALU_SELECTION_WIDTH-1:0] r_alu_s;

    logic [31:0] w_fwd_rs;
    logic [31:0] w_fwd_rt;
    logic        w_load_bubble;

    // Flush beats stall; an invalid ID slot only turns into a bubble when it is
    // actually being captured.
    assign w_load_bubble = flush || (!stall && !id_valid);

    // Bubbles also clear addresses and data so an empty slot can never match
    // a bypass path or look like a pending load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_src_imm   <= 1'b0;
            r_src_shamt <= 1'b0;
            r_rd        <= 5'd0;
            r_rs_addr   <= 5'd0;
            r_rt_addr   <= 5'd0;
            r_shamt     <= 5'd0;
            r_rs_data   <= 32'd0;
            r_rt_data   <= 32'd0;
            r_imm       <= 32'd0;
            r_alu_s     <= c_bubble_op;
        end else if (w_load_bubble) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_src_imm   <= 1'b0;
            r_src_shamt <= 1'b0;
            r_rd        <= 5'd0;
            r_rs_addr   <= 5'd0;
            r_rt_addr   <= 5'd0;
            r_shamt     <= 5'd0;
            r_rs_data   <= 32'd0;
            r_rt_data   <= 32'd0;
            r_imm       <= 32'd0;
            r_alu_s     <= c_bubble_op;
        end else if (!stall) begin
            r_valid     <= 1'b1;
            r_reg_write <= id_reg_write;
            r_mem_read  <= id_mem_read;
            r_mem_write <= id_mem_write;
            r_src_imm   <= id_src_imm;
            r_src_shamt <= id_src_shamt;
            r_rd        <= id_rd_addr;
            r_rs_addr   <= id_rs_addr;
            r_rt_addr   <= id_rt_addr;
            r_shamt     <= id_shamt;
            r_rs_data   <= id_rs_data;
            r_rt_data   <= id_rt_data;
            r_imm       <= id_imm;
            r_alu_s     <= id_alu_s;
        end
    end

    fwd_mux u_fwd_rs (
        .addr            (r_rs_addr),
        .reg_data        (r_rs_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .data            (w_fwd_rs)
    );

    fwd_mux u_fwd_rt (
        .addr            (r_rt_addr),
        .reg_data        (r_rt_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .data            (w_fwd_rt)
    );

    // Immediate shifts take the amount from shamt and shift rt; variable
    // shifts fall through to the rs/rt path with rs carrying the amount.
    always_comb begin
        alu_a = w_fwd_rs;
        alu_b = w_fwd_rt;
        if (r_src_shamt) begin
            alu_a = {27'd0, r_shamt};
            alu_b = w_fwd_rt;
        end else if (r_src_imm) begin
            alu_a = w_fwd_rs;
            alu_b = r_imm;
        end
    end

    assign alu_s         = r_alu_s;
    assign ex_valid      = r_valid;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_rd         = r_rd;
    assign ex_store_data = w_fwd_rt;

    assign load_use_hazard = r_valid && r_mem_read && (r_rd != 5'd0) &&
                             ((r_rd == id_rs_addr) ||
                              ((r_rd == id_rt_addr) && !id_src_imm));

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage: randomized traffic against
//               an instruction-level model plus directed corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int W = c_alu_sel_width;

    logic          clk;
    logic          rst;
    logic          stall, flush, id_valid;
    logic [4:0]    id_rs_addr, id_rt_addr, id_rd_addr, id_shamt;
    logic [31:0]   id_rs_data, id_rt_data, id_imm;
    logic [W-1:0]  id_alu_s;
    logic          id_src_imm, id_src_shamt, id_reg_write, id_mem_read, id_mem_write;
    logic          exmem_reg_write, memwb_reg_write;
    logic [4:0]    exmem_rd, memwb_rd;
    logic [31:0]   exmem_result, memwb_result;
    logic [31:0]   alu_a, alu_b, ex_store_data;
    logic [W-1:0]  alu_s;
    logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;
    logic [4:0]    ex_rd;

    int n_checks = 0;
    int n_fail   = 0;

    // One instruction as it sits in EX, described at instruction level.
    typedef struct {
        bit        valid, rw, mr, mw, si, ss;
        bit [4:0]  rd, rs, rt, shamt;
        bit [31:0] rsd, rtd, imm;
        bit [W-1:0] op;
    } instr_t;

    instr_t m;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_alu_s(id_alu_s), .id_src_imm(id_src_imm),
        .id_src_shamt(id_src_shamt), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_rd(ex_rd), .ex_store_data(ex_store_data), .load_use_hazard(load_use_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    function automatic instr_t bubble();
        instr_t b;
        b = '{default: '0};
        b.op = c_add_op;
        return b;
    endfunction

    function automatic instr_t from_id();
        instr_t c;
        c.valid = 1'b1;        c.rw = id_reg_write;  c.mr = id_mem_read;
        c.mw = id_mem_write;   c.si = id_src_imm;    c.ss = id_src_shamt;
        c.rd = id_rd_addr;     c.rs = id_rs_addr;    c.rt = id_rt_addr;
        c.shamt = id_shamt;    c.rsd = id_rs_data;   c.rtd = id_rt_data;
        c.imm = id_imm;        c.op = id_alu_s;
        return c;
    endfunction

    // Value an instruction sees for register r: newest in-flight writer wins.
    function automatic bit [31:0] operand(input bit [4:0] r, input bit [31:0] file_val);
        if (r == 0) return file_val;
        if (exmem_reg_write && exmem_rd == r) return exmem_result;
        if (memwb_reg_write && memwb_rd == r) return memwb_result;
        return file_val;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit [31:0] rs_v, rt_v, ea, eb;
        bit        hz;
        rs_v = operand(m.rs, m.rsd);
        rt_v = operand(m.rt, m.rtd);
        ea = m.ss ? 32'(m.shamt) : rs_v;
        eb = m.ss ? rt_v : (m.si ? m.imm : rt_v);
        hz = m.valid && m.mr && m.rd != 0 &&
             (m.rd == id_rs_addr || (m.rd == id_rt_addr && !id_src_imm));
        check("alu_a", alu_a, ea);
        check("alu_b", alu_b, eb);
        check("alu_s", 32'(alu_s), 32'(m.op));
        check("ex_valid", 32'(ex_valid), 32'(m.valid));
        check("ex_reg_write", 32'(ex_reg_write), 32'(m.rw));
        check("ex_mem_read", 32'(ex_mem_read), 32'(m.mr));
        check("ex_mem_write", 32'(ex_mem_write), 32'(m.mw));
        check("ex_rd", 32'(ex_rd), 32'(m.rd));
        check("ex_store_data", ex_store_data, rt_v);
        check("load_use_hazard", 32'(load_use_hazard), 32'(hz));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst)                             m = bubble();
        else if (flush)                       m = bubble();
        else if (!stall && !id_valid)         m = bubble();
        else if (!stall)                      m = from_id();
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; id_valid = 0;
        id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0; id_shamt = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alu_s = c_add_op;
        id_src_imm = 0; id_src_shamt = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic random_inputs();
        stall = ($urandom_range(0, 4) == 0);
        flush = ($urandom_range(0, 7) == 0);
        id_valid = ($urandom_range(0, 4) != 0);
        id_rs_addr = 5'($urandom_range(0, 3));
        id_rt_addr = 5'($urandom_range(0, 3));
        id_rd_addr = 5'($urandom_range(0, 3));
        id_shamt = 5'($urandom);
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_alu_s = W'($urandom_range(0, 10));
        id_src_imm = 1'($urandom); id_src_shamt = ($urandom_range(0, 3) == 0);
        id_reg_write = 1'($urandom); id_mem_read = 1'($urandom); id_mem_write = 1'($urandom);
        exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
        memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_result = $urandom;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        m = bubble();
        #1;
        check_all();
        tick();
        tick();
        check_all();
        check("reset_alu_s", 32'(alu_s), 32'(c_add_op));

        rst = 1'b1;
        tick();

        // Randomized traffic, with one asynchronous reset dropped mid-cycle.
        for (int i = 0; i < 300; i++) begin
            random_inputs();
            #1;
            check_all();
            if (i == 150) begin
                #2;
                rst = 1'b0;
                m = bubble();
                #1;
                check_all();
                tick();
                rst = 1'b1;
            end
            tick();
        end

        // Reset mid-operation forces zeros immediately.
        idle_inputs();
        id_valid = 1; id_rs_addr = 3; id_rt_addr = 4; id_rd_addr = 7;
        id_rs_data = 32'hAAAA_0001; id_rt_data = 32'hBBBB_0002; id_reg_write = 1;
        tick();
        check("live_before_reset", 32'(ex_valid), 32'd1);
        #2;
        rst = 1'b0;
        m = bubble();
        #1;
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_ex_reg_write", 32'(ex_reg_write), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);

        // Release reset while stalled: capture resumes on the first unstalled edge.
        stall = 1;
        tick();
        rst = 1'b1;
        tick();
        check("stall_after_reset", 32'(ex_valid), 32'd0);
        stall = 0;
        tick();
        check("resume_capture", alu_a, 32'hAAAA_0001);
        check_all();

        // Forwarding priority.
        idle_inputs();
        id_valid = 1; id_rs_addr = 5; id_rs_data = 32'h55; id_rt_addr = 6;
        tick();
        exmem_reg_write = 1; exmem_rd = 5; exmem_result = 32'h11;
        memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'h22;
        #1;
        check("fwd_exmem_first", alu_a, 32'h11);
        exmem_reg_write = 0;
        #1;
        check("fwd_memwb_second", alu_a, 32'h22);
        check_all();

        // Register 0 never forwarded.
        idle_inputs();
        id_valid = 1; id_rs_addr = 0; id_rs_data = 0;
        tick();
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hFFFF;
        memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'hEEEE;
        #1;
        check("r0_not_forwarded", alu_a, 32'd0);

        // Load-use: lw r8 then add r9,r8,r1 -> one bubble, then MEM/WB forward.
        idle_inputs();
        id_valid = 1; id_rs_addr = 2; id_rd_addr = 8; id_imm = 32'h10;
        id_src_imm = 1; id_reg_write = 1; id_mem_read = 1;
        tick();
        id_rs_addr = 8; id_rt_addr = 1; id_rd_addr = 9; id_rt_data = 32'h3;
        id_src_imm = 0; id_mem_read = 0; id_imm = 0;
        #1;
        check("lu_hazard_set", 32'(load_use_hazard), 32'd1);
        flush = 1;
        tick();
        flush = 0;
        exmem_reg_write = 1; exmem_rd = 8; exmem_result = 32'h0;
        #1;
        check("lu_bubble", 32'(ex_valid), 32'd0);
        check("lu_hazard_clear", 32'(load_use_hazard), 32'd0);
        tick();
        exmem_reg_write = 0; exmem_rd = 9;
        memwb_reg_write = 1; memwb_rd = 8; memwb_result = 32'hDEAD_BEEF;
        id_valid = 0; id_rs_addr = 0; id_rt_addr = 0;
        #1;
        check("lu_forward", alu_a, 32'hDEAD_BEEF);
        check("lu_add_valid", 32'(ex_valid), 32'd1);
        check_all();

        // Stall and flush on the same edge -> bubble; then a 3-cycle stall holds.
        idle_inputs();
        id_valid = 1; id_rs_addr = 11; id_rs_data = 32'h1234; id_rt_addr = 12;
        id_rt_data = 32'h5678; id_rd_addr = 13; id_reg_write = 1; id_alu_s = c_sub_op;
        stall = 1; flush = 1;
        tick();
        check("stall_flush_bubble", 32'(ex_valid), 32'd0);
        check("stall_flush_alu_s", 32'(alu_s), 32'(c_add_op));
        stall = 0; flush = 0;
        tick();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            id_rs_data = $urandom; id_rd_addr = 5'($urandom_range(1, 31));
            tick();
            check("hold_alu_a", alu_a, 32'h1234);
            check("hold_alu_b", alu_b, 32'h5678);
            check("hold_ex_rd", 32'(ex_rd), 32'd13);
            check("hold_alu_s", 32'(alu_s), 32'(c_sub_op));
        end
        check_all();

        // Immediate shift: sll with shamt 4 on rt = 1.
        idle_inputs();
        id_valid = 1; id_rt_addr = 3; id_rt_data = 32'h1; id_shamt = 4;
        id_src_shamt = 1; id_alu_s = c_sl_op; id_rd_addr = 2; id_reg_write = 1;
        tick();
        check("sll_alu_a", alu_a, 32'd4);
        check("sll_alu_b", alu_b, 32'h1);
        check("sll_alu_s", 32'(alu_s), 32'(c_sl_op));
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
